// File: rtl/spi_burst_peripheral.sv
// spi_burst_peripheral
//   SPI target bridging an external SPI controller onto the internal
//   subperipheral address/data interface. A transaction is an address
//   (ADDRESS_WIDTH bits, MSB first) followed by any number of DATA_WIDTH-bit
//   words. Every complete word is presented as a write, and a read word is
//   requested for each word address and shifted out on CIPO. The address
//   optionally auto-increments per word. All four SPI modes are supported.
//
// Ports
//   system_clock / system_reset        : single clock, synchronous active-high reset
//   spi_select_in / spi_clock_in /
//   spi_data_in                        : asynchronous SPI pins (CS_n, SCLK, COPI)
//   spi_data_out                       : CIPO, registered
//   subperipheral_address_out(_valid)  : current word address, valid while in data phase
//   subperipheral_data_out(_valid)     : last complete write word, one-cycle pulse
//   subperipheral_read_request_out     : one-cycle pulse requesting the read word
//   subperipheral_data_in(_valid)      : read word and its one-cycle qualifier
//   read_underrun_out                  : sticky, a word started before its read data arrived
//   select_abort_out                   : sticky, select deasserted mid-word
module spi_burst_peripheral #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int CPOL           = 0,
  parameter int CPHA           = 0,
  parameter int AUTO_INCREMENT = 1
) (
  input  logic                     system_clock,
  input  logic                     system_reset,
  input  logic                     spi_select_in,
  input  logic                     spi_clock_in,
  input  logic                     spi_data_in,
  output logic                     spi_data_out,
  output logic [ADDRESS_WIDTH-1:0] subperipheral_address_out,
  output logic                     subperipheral_address_out_valid,
  output logic [DATA_WIDTH-1:0]    subperipheral_data_out,
  output logic                     subperipheral_data_out_valid,
  output logic                     subperipheral_read_request_out,
  input  logic [DATA_WIDTH-1:0]    subperipheral_data_in,
  input  logic                     subperipheral_data_in_valid,
  output logic                     read_underrun_out,
  output logic                     select_abort_out
);

  localparam int MAXW = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] A_START = CW'(ADDRESS_WIDTH - 1);
  localparam logic [CW-1:0] D_START = CW'(DATA_WIDTH - 1);
  localparam logic IDLE_LVL    = (CPOL != 0);
  localparam logic SAMPLE_RISE = (CPOL == CPHA);
  localparam logic LATE_SAMPLE = (CPHA != 0);
  localparam logic AUTO_INC    = (AUTO_INCREMENT != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDRESS, ST_DATA} state_e;

  // Synchronisers. Select resets to the active (low) level so that a select
  // held low across reset release never looks like a fresh falling edge.
  logic sel_m_q, sel_s_q, sel_p_q;
  logic clk_m_q, clk_s_q, clk_p_q;
  logic dat_m_q, dat_s_q;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_sr_q, addr_sr_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     addr_vld_q, addr_vld_d;
  logic [DATA_WIDTH-1:0]    wr_sr_q, wr_sr_d;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     dout_vld_q, dout_vld_d;
  logic                     rreq_q, rreq_d;
  logic                     word_done_q, word_done_d;
  logic [DATA_WIDTH-1:0]    rd_sr_q, rd_sr_d;
  logic                     loaded_q, loaded_d;
  logic                     fshift_q, fshift_d;
  logic                     cipo_q, cipo_d;
  logic                     underrun_q, underrun_d;
  logic                     abort_q, abort_d;

  logic rise, fall, sample_edge, shift_edge, sel_fall, load_ok;

  assign rise        = clk_s_q & ~clk_p_q;
  assign fall        = ~clk_s_q & clk_p_q;
  assign sample_edge = SAMPLE_RISE ? rise : fall;
  assign shift_edge  = SAMPLE_RISE ? fall : rise;
  assign sel_fall    = sel_p_q & ~sel_s_q;

  // Read data may load only while the current word has neither been sampled
  // nor (CPHA=1) had its MSB-launching shift edge.
  assign load_ok = subperipheral_data_in_valid && (state_q == ST_DATA) && !sel_s_q &&
                   (cnt_q == D_START) && !fshift_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_sr_d   = addr_sr_q;
    addr_d      = addr_q;
    addr_vld_d  = addr_vld_q;
    wr_sr_d     = wr_sr_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    rreq_d      = 1'b0;
    word_done_d = 1'b0;
    rd_sr_d     = rd_sr_q;
    loaded_d    = loaded_q;
    fshift_d    = fshift_q;
    underrun_d  = underrun_q;
    abort_d     = abort_q;

    // Address advance is deferred one cycle so the address is stable
    // throughout the data_out_valid pulse.
    if (word_done_q && state_q == ST_DATA && !sel_s_q) begin
      if (AUTO_INC) addr_d = addr_q + ADDRESS_WIDTH'(1);
      rreq_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        addr_vld_d = 1'b0;
        if (sel_fall) begin
          state_d = ST_ADDRESS;
          cnt_d   = A_START;
        end
      end
      ST_ADDRESS: begin
        if (sel_s_q) begin
          state_d = ST_IDLE;
          if (cnt_q != A_START) abort_d = 1'b1;
        end else if (sample_edge) begin
          addr_sr_d = ADDRESS_WIDTH'({addr_sr_q, dat_s_q});
          if (cnt_q == '0) begin
            addr_d     = addr_sr_d;
            addr_vld_d = 1'b1;
            rreq_d     = 1'b1;
            state_d    = ST_DATA;
            cnt_d      = D_START;
            rd_sr_d    = '0;
            loaded_d   = 1'b0;
            fshift_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_DATA: begin
        if (sel_s_q) begin
          state_d    = ST_IDLE;
          addr_vld_d = 1'b0;
          if (cnt_q != D_START) abort_d = 1'b1;
        end else begin
          if (load_ok) begin
            rd_sr_d  = subperipheral_data_in;
            loaded_d = 1'b1;
          end
          // A shift edge before the first sample only launches the MSB,
          // which is already on the pin, so it does not advance the register.
          if (shift_edge) begin
            if (cnt_q != D_START) begin
              rd_sr_d = DATA_WIDTH'({rd_sr_q, 1'b0});
            end else if (LATE_SAMPLE) begin
              fshift_d = 1'b1;
            end
          end
          if (sample_edge) begin
            wr_sr_d = DATA_WIDTH'({wr_sr_q, dat_s_q});
            if (cnt_q == D_START && !loaded_q && !load_ok) underrun_d = 1'b1;
            if (cnt_q == '0) begin
              dout_d      = wr_sr_d;
              dout_vld_d  = 1'b1;
              word_done_d = 1'b1;
              cnt_d       = D_START;
              rd_sr_d     = '0;
              loaded_d    = 1'b0;
              fshift_d    = 1'b0;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cipo_d = (state_d == ST_DATA) ? rd_sr_d[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      sel_m_q     <= 1'b0;
      sel_s_q     <= 1'b0;
      sel_p_q     <= 1'b0;
      clk_m_q     <= IDLE_LVL;
      clk_s_q     <= IDLE_LVL;
      clk_p_q     <= IDLE_LVL;
      dat_m_q     <= 1'b0;
      dat_s_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_sr_q   <= '0;
      addr_q      <= '0;
      addr_vld_q  <= 1'b0;
      wr_sr_q     <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      rreq_q      <= 1'b0;
      word_done_q <= 1'b0;
      rd_sr_q     <= '0;
      loaded_q    <= 1'b0;
      fshift_q    <= 1'b0;
      cipo_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sel_m_q     <= spi_select_in;
      sel_s_q     <= sel_m_q;
      sel_p_q     <= sel_s_q;
      clk_m_q     <= spi_clock_in;
      clk_s_q     <= clk_m_q;
      clk_p_q     <= clk_s_q;
      dat_m_q     <= spi_data_in;
      dat_s_q     <= dat_m_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_sr_q   <= addr_sr_d;
      addr_q      <= addr_d;
      addr_vld_q  <= addr_vld_d;
      wr_sr_q     <= wr_sr_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      rreq_q      <= rreq_d;
      word_done_q <= word_done_d;
      rd_sr_q     <= rd_sr_d;
      loaded_q    <= loaded_d;
      fshift_q    <= fshift_d;
      cipo_q      <= cipo_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign spi_data_out                    = cipo_q;
  assign subperipheral_address_out       = addr_q;
  assign subperipheral_address_out_valid = addr_vld_q;
  assign subperipheral_data_out          = dout_q;
  assign subperipheral_data_out_valid    = dout_vld_q;
  assign subperipheral_read_request_out  = rreq_q;
  assign read_underrun_out               = underrun_q;
  assign select_abort_out                = abort_q;

endmodule

// File: tb/tb_spi_burst_peripheral.sv
// Bench for spi_burst_peripheral: four instances in different modes/widths,
// each with its own SPI pins, sharing clock and reset.
//   0: mode 0, 8/8,  auto-increment
//   1: mode 3, 16/32, no auto-increment
//   2: mode 3, 16/32, auto-increment
//   3: mode 1, 8/8,  auto-increment
module tb_spi_burst_peripheral;

  localparam int HALF = 8;
  localparam int CPOLS[4] = '{0, 1, 1, 0};
  localparam int CPHAS[4] = '{0, 1, 1, 1};
  localparam int AWS[4]   = '{8, 16, 16, 8};
  localparam int DWS[4]   = '{8, 32, 32, 8};
  localparam int AIS[4]   = '{1, 0, 1, 1};

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel[4], sck[4], mosi[4], miso[4];
  logic avld[4], dvld[4], rq[4], divld[4], unr[4], abt[4];
  logic [31:0] aout[4], dout[4], din[4];
  logic [7:0]  a0, a3, d0, d3;
  logic [15:0] a1, a2;
  logic [31:0] d1, d2;

  int total = 0;
  int bad   = 0;
  ev_t wq[$];
  ev_t rqq[$];
  logic [31:0] last_a[4], last_d[4];
  int sel_hi[4];
  logic rsp_en[4];
  int rsp_cnt[4];
  logic [7:0] rsp_addr[4];
  logic [7:0] mem[256];

  always #5 clk = ~clk;

  assign aout[0] = {24'h0, a0};
  assign aout[1] = {16'h0, a1};
  assign aout[2] = {16'h0, a2};
  assign aout[3] = {24'h0, a3};
  assign dout[0] = {24'h0, d0};
  assign dout[1] = d1;
  assign dout[2] = d2;
  assign dout[3] = {24'h0, d3};

  spi_burst_peripheral #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .CPOL(0), .CPHA(0), .AUTO_INCREMENT(1)) u0 (
    .system_clock(clk), .system_reset(rst), .spi_select_in(sel[0]), .spi_clock_in(sck[0]),
    .spi_data_in(mosi[0]), .spi_data_out(miso[0]), .subperipheral_address_out(a0),
    .subperipheral_address_out_valid(avld[0]), .subperipheral_data_out(d0),
    .subperipheral_data_out_valid(dvld[0]), .subperipheral_read_request_out(rq[0]),
    .subperipheral_data_in(din[0][7:0]), .subperipheral_data_in_valid(divld[0]),
    .read_underrun_out(unr[0]), .select_abort_out(abt[0]));

  spi_burst_peripheral #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .CPOL(1), .CPHA(1), .AUTO_INCREMENT(0)) u1 (
    .system_clock(clk), .system_reset(rst), .spi_select_in(sel[1]), .spi_clock_in(sck[1]),
    .spi_data_in(mosi[1]), .spi_data_out(miso[1]), .subperipheral_address_out(a1),
    .subperipheral_address_out_valid(avld[1]), .subperipheral_data_out(d1),
    .subperipheral_data_out_valid(dvld[1]), .subperipheral_read_request_out(rq[1]),
    .subperipheral_data_in(din[1]), .subperipheral_data_in_valid(divld[1]),
    .read_underrun_out(unr[1]), .select_abort_out(abt[1]));

  spi_burst_peripheral #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .CPOL(1), .CPHA(1), .AUTO_INCREMENT(1)) u2 (
    .system_clock(clk), .system_reset(rst), .spi_select_in(sel[2]), .spi_clock_in(sck[2]),
    .spi_data_in(mosi[2]), .spi_data_out(miso[2]), .subperipheral_address_out(a2),
    .subperipheral_address_out_valid(avld[2]), .subperipheral_data_out(d2),
    .subperipheral_data_out_valid(dvld[2]), .subperipheral_read_request_out(rq[2]),
    .subperipheral_data_in(din[2]), .subperipheral_data_in_valid(divld[2]),
    .read_underrun_out(unr[2]), .select_abort_out(abt[2]));

  spi_burst_peripheral #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .CPOL(0), .CPHA(1), .AUTO_INCREMENT(1)) u3 (
    .system_clock(clk), .system_reset(rst), .spi_select_in(sel[3]), .spi_clock_in(sck[3]),
    .spi_data_in(mosi[3]), .spi_data_out(miso[3]), .subperipheral_address_out(a3),
    .subperipheral_address_out_valid(avld[3]), .subperipheral_data_out(d3),
    .subperipheral_data_out_valid(dvld[3]), .subperipheral_read_request_out(rq[3]),
    .subperipheral_data_in(din[3][7:0]), .subperipheral_data_in_valid(divld[3]),
    .read_underrun_out(unr[3]), .select_abort_out(abt[3]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected address of word i in a burst starting at 'base'.
  function automatic logic [31:0] word_addr(input int k, input logic [31:0] base, input int i);
    logic [31:0] mask;
    mask = (32'h1 << AWS[k]) - 32'h1;
    return (AIS[k] != 0) ? ((base + 32'(i)) & mask) : base;
  endfunction

  task automatic hw();
    repeat (HALF) @(negedge clk);
  endtask

  // Controller side: n bits MSB first, CIPO captured on each sample edge.
  task automatic send_bits(input int k, input logic [31:0] bits, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (CPHAS[k] == 0) begin
        mosi[k] = bits[i];
        hw();
        sck[k] = (CPOLS[k] == 0);
        rx = {rx[30:0], miso[k]};
        hw();
        sck[k] = (CPOLS[k] != 0);
      end else begin
        sck[k] = (CPOLS[k] == 0);
        mosi[k] = bits[i];
        hw();
        sck[k] = (CPOLS[k] != 0);
        rx = {rx[30:0], miso[k]};
        hw();
      end
    end
  endtask

  // Full transaction of nw (1 or 2) words; the expected writes and read
  // requests are queued from the addressing rules before driving the pins.
  task automatic spi_txn(input int k, input logic [31:0] base, input int nw,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input bit rchk, input logic [31:0] r0, input logic [31:0] r1);
    logic [31:0] rx;
    logic [31:0] mask;
    mask = (DWS[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << DWS[k]) - 32'h1);
    rqq.push_back('{k: 2'(k), a: base, d: 32'h0});
    for (int i = 0; i < nw; i++) begin
      wq.push_back('{k: 2'(k), a: word_addr(k, base, i), d: (i == 0) ? w0 : w1});
      rqq.push_back('{k: 2'(k), a: word_addr(k, base, i + 1), d: 32'h0});
    end
    sel[k] = 1'b0;
    hw();
    send_bits(k, base, AWS[k], rx);
    for (int i = 0; i < nw; i++) begin
      send_bits(k, (i == 0) ? w0 : w1, DWS[k], rx);
      if (rchk) check($sformatf("cipo word%0d dut%0d", i, k), rx & mask, (i == 0) ? r0 : r1);
    end
    hw();
    sel[k] = 1'b1;
    hw();
    hw();
  endtask

  // Read-data responder: answers a request 1-2 cycles later with mem[address].
  initial begin
    for (int k = 0; k < 4; k++) begin
      divld[k] = 1'b0;
      din[k] = '0;
      rsp_cnt[k] = 0;
      rsp_addr[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        divld[k] = 1'b0;
        if (rsp_cnt[k] == 1) begin
          divld[k] = 1'b1;
          din[k] = {24'h0, mem[rsp_addr[k]]};
          rsp_cnt[k] = 0;
        end
        if (rq[k] && rsp_en[k]) begin
          rsp_cnt[k] = 1;
          rsp_addr[k] = aout[k][7:0];
        end
      end
    end
  end

  // Compare process: every write pulse and read request against the queues,
  // and the idle outputs whenever select has been high for a while.
  initial begin
    ev_t e;
    for (int k = 0; k < 4; k++) begin
      sel_hi[k] = 0;
      last_a[k] = '0;
      last_d[k] = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (dvld[k]) begin
          if (wq.size() == 0) begin
            check($sformatf("unexpected write dut%0d", k), dout[k], 32'hxxxx_xxxx);
          end else begin
            e = wq.pop_front();
            check("write dut", 32'(k), 32'(e.k));
            check($sformatf("write data dut%0d", k), dout[k], e.d);
            check($sformatf("write addr dut%0d", k), aout[k], e.a);
            check($sformatf("write addr_valid dut%0d", k), 32'(avld[k]), 32'h1);
          end
          last_a[k] = aout[k];
          last_d[k] = dout[k];
        end
        if (rq[k]) begin
          if (rqq.size() == 0) begin
            check($sformatf("unexpected read request dut%0d", k), aout[k], 32'hxxxx_xxxx);
          end else begin
            e = rqq.pop_front();
            check("rreq dut", 32'(k), 32'(e.k));
            check($sformatf("rreq addr dut%0d", k), aout[k], e.a);
            check($sformatf("rreq addr_valid dut%0d", k), 32'(avld[k]), 32'h1);
          end
        end
        sel_hi[k] = sel[k] ? sel_hi[k] + 1 : 0;
        if (sel_hi[k] >= 4) begin
          check($sformatf("idle addr_valid dut%0d", k), 32'(avld[k]), 32'h0);
          check($sformatf("idle cipo dut%0d", k), 32'(miso[k]), 32'h0);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h96;
    mem[8'h40] = 8'hC3;
    mem[8'h41] = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      sel[k] = 1'b1;
      sck[k] = (CPOLS[k] != 0);
      mosi[k] = 1'b0;
      rsp_en[k] = 1'b0;
    end
    rsp_en[0] = 1'b1;
    rsp_en[3] = 1'b1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset addr dut%0d", k), aout[k], 32'h0);
      check($sformatf("reset data dut%0d", k), dout[k], 32'h0);
      check($sformatf("reset flags dut%0d", k),
            {28'h0, avld[k], dvld[k], rq[k], miso[k]} | {30'h0, unr[k], abt[k]}, 32'h0);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Mode 0 burst write with auto-increment.
    spi_txn(0, 32'h12, 2, 32'hA5, 32'h3C, 1'b0, 32'h0, 32'h0);
    check("m0 last write addr", last_a[0], 32'h13);
    check("m0 last write data", last_d[0], 32'h3C);
    check("m0 underrun", 32'(unr[0]), 32'h0);

    // Mode 3, 16/32, address 0xFFFF without and with auto-increment.
    spi_txn(1, 32'hFFFF, 2, 32'hDEADBEEF, 32'h01234567, 1'b0, 32'h0, 32'h0);
    check("m3 hold last addr", last_a[1], 32'hFFFF);
    check("m3 hold last data", last_d[1], 32'h01234567);
    spi_txn(2, 32'hFFFF, 2, 32'hCAFEF00D, 32'h89ABCDEF, 1'b0, 32'h0, 32'h0);
    check("m3 wrap last addr", last_a[2], 32'h0000);
    check("m3 wrap last data", last_d[2], 32'h89ABCDEF);

    // Mode 1 burst read from 0x40.
    spi_txn(3, 32'h40, 2, 32'h00, 32'h00, 1'b1, 32'hC3, 32'h5A);
    check("m1 underrun", 32'(unr[3]), 32'h0);
    check("m1 abort", 32'(abt[3]), 32'h0);

    // Abort after 5 data bits, then a normal transaction.
    rqq.push_back('{k: 2'd0, a: 32'h20, d: 32'h0});
    sel[0] = 1'b0;
    hw();
    send_bits(0, 32'h20, 8, rx);
    send_bits(0, 32'h16, 5, rx);
    sel[0] = 1'b1;
    repeat (4) @(negedge clk);
    check("abort addr_valid", 32'(avld[0]), 32'h0);
    check("abort flag", 32'(abt[0]), 32'h1);
    hw();
    spi_txn(0, 32'h21, 1, 32'h77, 32'h0, 1'b0, 32'h0, 32'h0);
    check("post-abort write addr", last_a[0], 32'h21);
    check("post-abort write data", last_d[0], 32'h77);
    check("abort sticky", 32'(abt[0]), 32'h1);

    // Mode 0 read with no read data supplied.
    rsp_en[0] = 1'b0;
    spi_txn(0, 32'h50, 1, 32'h99, 32'h0, 1'b1, 32'h00, 32'h0);
    check("m0 underrun set", 32'(unr[0]), 32'h1);
    repeat (20) @(negedge clk);
    check("m0 underrun sticky", 32'(unr[0]), 32'h1);

    // Reset mid-word with select held low: no activity until select toggles.
    rqq.push_back('{k: 2'd0, a: 32'h30, d: 32'h0});
    sel[0] = 1'b0;
    hw();
    send_bits(0, 32'h30, 8, rx);
    send_bits(0, 32'h5, 3, rx);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_bits(0, 32'h1B, 5, rx);
    send_bits(0, 32'hE4, 8, rx);
    check("post-reset addr", aout[0], 32'h0);
    check("post-reset data", dout[0], 32'h0);
    check("post-reset addr_valid", 32'(avld[0]), 32'h0);
    check("post-reset cipo", 32'(miso[0]), 32'h0);
    check("post-reset underrun", 32'(unr[0]), 32'h0);
    check("post-reset abort", 32'(abt[0]), 32'h0);
    sel[0] = 1'b1;
    hw();
    hw();
    rsp_en[0] = 1'b1;
    spi_txn(0, 32'hFE, 2, 32'h11, 32'h22, 1'b0, 32'h0, 32'h0);
    check("post-reset wrap addr", last_a[0], 32'hFF);
    check("post-reset write data", last_d[0], 32'h22);

    repeat (10) @(negedge clk);
    check("pending writes", 32'(wq.size()), 32'h0);
    check("pending read requests", 32'(rqq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
